// File: rtl/pipe_pkg.sv
// Shared types for the MEM pipeline stage: FSM states, EX/MEM and MEM/WB register layouts.
package pipe_pkg;

   localparam int WORD_W = 32;

   typedef enum logic {
      IDLE,
      ACCESS
   } mem_state_e;

   typedef struct packed {
      logic [WORD_W-1:0] alu_result;
      logic [WORD_W-1:0] write_data;
      logic [4:0]        write_reg;
      logic              mem_read;
      logic              mem_write;
      logic              reg_write;
      logic              mem_to_reg;
   } ex_mem_t;

   typedef struct packed {
      logic [4:0]        write_reg;
      logic              reg_write;
      logic [WORD_W-1:0] write_data;
   } mem_wb_t;

   function automatic logic is_mem_op(input logic rd, input logic wr);
      return rd | wr;
   endfunction

endpackage

// File: rtl/mem_stage_if.sv
// Data-memory bus with a req/ack handshake; the pipeline is master, the memory is slave.
interface mem_stage_if #(
   parameter int ADDR_W = 32
) ();

   logic              dmem_req;
   logic              dmem_we;
   logic [ADDR_W-1:0] dmem_addr;
   logic [31:0]       dmem_wdata;
   logic [31:0]       dmem_rdata;
   logic              dmem_ack;

   modport master (
      output dmem_req, dmem_we, dmem_addr, dmem_wdata,
      input  dmem_rdata, dmem_ack
   );

   modport slave (
      input  dmem_req, dmem_we, dmem_addr, dmem_wdata,
      output dmem_rdata, dmem_ack
   );

endinterface

// File: rtl/mem_stage_bus_fsm.sv
// Bus-access controller for the MEM stage: IDLE/ACCESS state, wait counter, stall and timeout.
module mem_bus_fsm
   import pipe_pkg::*;
#(
   parameter int TIMEOUT_CYCLES = 16
) (
   input  logic clk,
   input  logic rst,
   input  logic next_mem_op,
   input  logic ack,
   input  logic abort,
   output logic req,
   output logic mem_stall,
   output logic timeout_hit,
   output logic bus_error
);

   localparam logic [7:0] LAST_WAIT = 8'(TIMEOUT_CYCLES - 1);

   mem_state_e state, state_next;
   logic [7:0] count, count_next;
   logic       ack_ok;

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
         count <= '0;
      end else begin
         state <= state_next;
         count <= count_next;
      end
   end

   // An aborted (misaligned) access never raises req and is retired like a timeout.
   always_comb begin
      req         = 1'b0;
      ack_ok      = 1'b0;
      timeout_hit = 1'b0;
      mem_stall   = 1'b0;
      count_next  = '0;
      state_next  = state;
      if (state == ACCESS) begin
         req         = ~abort;
         ack_ok      = ack & ~abort;
         timeout_hit = abort | ((count == LAST_WAIT) & ~ack);
         mem_stall   = ~ack_ok & ~timeout_hit;
         if (mem_stall) count_next = count + 8'd1;
      end
      if (!mem_stall) state_next = next_mem_op ? ACCESS : IDLE;
   end

   assign bus_error = timeout_hit & ~rst;

endmodule

// File: rtl/mem_stage.sv
// Pipeline MEM stage: EX/MEM latch, data-memory access, MEM/WB register and forwarding sources.
// Optional define MEM_STAGE_ALIGN_CHECK_EN rejects word-misaligned accesses without touching the bus.
module mem_stage
   import pipe_pkg::*;
#(
   parameter int TIMEOUT_CYCLES = 16,
   parameter int ADDR_W         = 32
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [WORD_W-1:0] alu_result,
   input  logic [WORD_W-1:0] write_data,
   input  logic [4:0]        write_reg,
   input  logic              mem_read,
   input  logic              mem_write,
   input  logic              reg_write,
   input  logic              mem_to_reg,
   mem_stage_if.master       dmem,
   output logic              mem_stall,
   output logic [WORD_W-1:0] EX_MEM_alu_result,
   output logic [4:0]        EX_MEM_write_reg,
   output logic              EX_MEM_reg_write,
   output logic [4:0]        MEM_WB_write_reg,
   output logic              MEM_WB_reg_write,
   output logic [WORD_W-1:0] MEM_WB_write_data,
   output logic              bus_error
);

   ex_mem_t ex_mem;
   mem_wb_t mem_wb;
   logic    timeout_hit;
   logic    misaligned;

   // Read+write together is illegal; demoting the write makes it a plain load.
   always_ff @(posedge clk) begin
      if (rst) begin
         ex_mem <= '0;
      end else if (!mem_stall) begin
         ex_mem <= '{alu_result, write_data, write_reg, mem_read,
                     mem_write & ~mem_read, reg_write, mem_to_reg};
      end
   end

`ifdef MEM_STAGE_ALIGN_CHECK_EN
   assign misaligned = is_mem_op(ex_mem.mem_read, ex_mem.mem_write)
                       & (ex_mem.alu_result[1:0] != 2'b00);
`else
   assign misaligned = 1'b0;
`endif

   mem_bus_fsm #(
      .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
   ) u_fsm (
      .clk        (clk),
      .rst        (rst),
      .next_mem_op(is_mem_op(mem_read, mem_write)),
      .ack        (dmem.dmem_ack),
      .abort      (misaligned),
      .req        (dmem.dmem_req),
      .mem_stall  (mem_stall),
      .timeout_hit(timeout_hit),
      .bus_error  (bus_error)
   );

   assign dmem.dmem_we    = ex_mem.mem_write;
   assign dmem.dmem_addr  = ex_mem.alu_result[ADDR_W-1:0];
   assign dmem.dmem_wdata = ex_mem.write_data;

   // Stores and abandoned accesses still flow to MEM/WB but never write the register file.
   always_ff @(posedge clk) begin
      if (rst || mem_stall) begin
         mem_wb <= '0;
      end else begin
         mem_wb.write_reg  <= ex_mem.write_reg;
         mem_wb.reg_write  <= ex_mem.reg_write & ~ex_mem.mem_write & ~timeout_hit;
         mem_wb.write_data <= ex_mem.mem_to_reg ? dmem.dmem_rdata : ex_mem.alu_result;
      end
   end

   assign EX_MEM_alu_result = ex_mem.alu_result;
   assign EX_MEM_write_reg  = ex_mem.write_reg;
   assign EX_MEM_reg_write  = ex_mem.reg_write;
   assign MEM_WB_write_reg  = mem_wb.write_reg;
   assign MEM_WB_reg_write  = mem_wb.reg_write;
   assign MEM_WB_write_data = mem_wb.write_data;

endmodule

// File: tb/tb_mem_stage.sv
// Randomised bench for mem_stage: a memory responder with planned ack delays and a per-instruction
// reference model that derives stall length, bus errors and writeback values from each instruction.
module tb_mem_stage;
   import pipe_pkg::*;

   localparam int T     = 4;
   localparam int NEVER = 99;

   typedef struct {
      logic [31:0] alu;
      logic [31:0] wdata;
      logic [31:0] rdata;
      logic [4:0]  wreg;
      logic        rd;
      logic        wr;
      logic        rw;
      logic        m2r;
      int          d;
   } instr_t;

   logic        clk = 1'b0;
   logic        rst;
   logic [31:0] alu_result, write_data;
   logic [4:0]  write_reg;
   logic        mem_read, mem_write, reg_write, mem_to_reg;
   logic        mem_stall, bus_error;
   logic [31:0] EX_MEM_alu_result, MEM_WB_write_data;
   logic [4:0]  EX_MEM_write_reg, MEM_WB_write_reg;
   logic        EX_MEM_reg_write, MEM_WB_reg_write;

   mem_stage_if #(.ADDR_W(32)) dmem ();

   mem_stage #(.TIMEOUT_CYCLES(T), .ADDR_W(32)) dut (
      .clk              (clk),
      .rst              (rst),
      .alu_result       (alu_result),
      .write_data       (write_data),
      .write_reg        (write_reg),
      .mem_read         (mem_read),
      .mem_write        (mem_write),
      .reg_write        (reg_write),
      .mem_to_reg       (mem_to_reg),
      .dmem             (dmem),
      .mem_stall        (mem_stall),
      .EX_MEM_alu_result(EX_MEM_alu_result),
      .EX_MEM_write_reg (EX_MEM_write_reg),
      .EX_MEM_reg_write (EX_MEM_reg_write),
      .MEM_WB_write_reg (MEM_WB_write_reg),
      .MEM_WB_reg_write (MEM_WB_reg_write),
      .MEM_WB_write_data(MEM_WB_write_data),
      .bus_error        (bus_error)
   );

   always #5 clk = ~clk;

   int          vectors = 0;
   int          miscompares = 0;
   logic [4:0]  prev_reg;
   logic        prev_rw;
   logic [31:0] prev_data;
   instr_t      prog[$];

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      vectors++;
      if (observed !== expected) begin
         miscompares++;
         $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h at %0t", tag, observed, expected, $time);
      end
   endtask

   task automatic applyStimulus(input instr_t x);
      alu_result = x.alu;
      write_data = x.wdata;
      write_reg  = x.wreg;
      mem_read   = x.rd;
      mem_write  = x.wr;
      reg_write  = x.rw;
      mem_to_reg = x.m2r;
   endtask

   function automatic instr_t mk(input logic [31:0] alu, input logic [31:0] wdata, input logic [31:0] rdata,
                                 input logic [4:0] wreg, input logic rd, input logic wr,
                                 input logic rw, input logic m2r, input int d);
      instr_t x;
      x.alu = alu; x.wdata = wdata; x.rdata = rdata; x.wreg = wreg;
      x.rd = rd; x.wr = wr; x.rw = rw; x.m2r = m2r; x.d = d;
      return x;
   endfunction

   function automatic instr_t randInstr();
      instr_t      x;
      logic [31:0] a;
      int          kind;
      kind = $urandom_range(0, 3);
      a = $urandom;
      if ($urandom_range(0, 7) != 0) a[1:0] = 2'b00;
      x.alu   = a;
      x.wdata = $urandom;
      x.rdata = $urandom;
      x.wreg  = 5'($urandom_range(0, 31));
      x.rd    = (kind == 1) || (kind == 3);
      x.wr    = (kind == 2) || (kind == 3);
      x.rw    = 1'($urandom_range(0, 1));
      x.m2r   = x.rd ? ($urandom_range(0, 4) != 0) : ($urandom_range(0, 4) == 0);
      x.d     = $urandom_range(0, 5);
      if (x.d > T) x.d = NEVER;
      return x;
   endfunction

   // Runs one instruction from capture to retirement; nxt is presented in its completing cycle.
   task automatic runInstr(input instr_t x, input instr_t nxt);
      logic mem, store, mis, timed;
      int   latency;
      mem   = x.rd | x.wr;
      store = x.wr & ~x.rd;
`ifdef MEM_STAGE_ALIGN_CHECK_EN
      mis = mem && (x.alu[1:0] != 2'b00);
`else
      mis = 1'b0;
`endif
      if (!mem || mis) latency = 0;
      else latency = (x.d <= T - 1) ? x.d : T - 1;
      timed = mem && (mis || x.d > T - 1);
      for (int c = 0; c <= latency; c++) begin
         @(posedge clk);
         #1;
         if (mem && !mis) dmem.dmem_ack = (c == x.d);
         else dmem.dmem_ack = 1'($urandom_range(0, 1));
         dmem.dmem_rdata = (c == latency) ? x.rdata : $urandom;
         if (c == latency) applyStimulus(nxt);
         #1;
         checkOutput("dmem_req", 32'(dmem.dmem_req), 32'(mem && !mis));
         checkOutput("mem_stall", 32'(mem_stall), 32'(c < latency));
         checkOutput("bus_error", 32'(bus_error), 32'(timed && c == latency));
         if (mem && !mis) begin
            checkOutput("dmem_we", 32'(dmem.dmem_we), 32'(store));
            checkOutput("dmem_addr", dmem.dmem_addr, x.alu);
            checkOutput("dmem_wdata", dmem.dmem_wdata, x.wdata);
         end
         checkOutput("EX_MEM_alu_result", EX_MEM_alu_result, x.alu);
         checkOutput("EX_MEM_write_reg", 32'(EX_MEM_write_reg), 32'(x.wreg));
         checkOutput("EX_MEM_reg_write", 32'(EX_MEM_reg_write), 32'(x.rw));
         checkOutput("MEM_WB_write_reg", 32'(MEM_WB_write_reg), (c == 0) ? 32'(prev_reg) : 32'd0);
         checkOutput("MEM_WB_reg_write", 32'(MEM_WB_reg_write), (c == 0) ? 32'(prev_rw) : 32'd0);
         checkOutput("MEM_WB_write_data", MEM_WB_write_data, (c == 0) ? prev_data : 32'd0);
      end
      prev_reg  = x.wreg;
      prev_rw   = x.rw && !store && !timed;
      prev_data = x.m2r ? x.rdata : x.alu;
   endtask

   task automatic checkAllClear(input string tag);
      checkOutput({tag, "_req"}, 32'(dmem.dmem_req), 32'd0);
      checkOutput({tag, "_stall"}, 32'(mem_stall), 32'd0);
      checkOutput({tag, "_bus_error"}, 32'(bus_error), 32'd0);
      checkOutput({tag, "_addr"}, dmem.dmem_addr, 32'd0);
      checkOutput({tag, "_ex_mem"}, EX_MEM_alu_result, 32'd0);
      checkOutput({tag, "_ex_mem_rw"}, 32'(EX_MEM_reg_write), 32'd0);
      checkOutput({tag, "_wb_rw"}, 32'(MEM_WB_reg_write), 32'd0);
      checkOutput({tag, "_wb_data"}, MEM_WB_write_data, 32'd0);
   endtask

   initial begin
      instr_t nop, lw_hang;
      nop     = mk(32'h0, 32'h0, 32'h0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 0);
      lw_hang = mk(32'h100, 32'h0, 32'h1357_9BDF, 5'd9, 1'b1, 1'b0, 1'b1, 1'b1, NEVER);

      prog.push_back(mk(32'h1234, 32'h0, 32'h0, 5'd5, 1'b0, 1'b0, 1'b1, 1'b0, 0));
      prog.push_back(mk(32'h40, 32'h0, 32'hDEAD_BEEF, 5'd7, 1'b1, 1'b0, 1'b1, 1'b1, 3));
      prog.push_back(mk(32'h80, 32'hA5A5_A5A5, 32'h0, 5'd3, 1'b0, 1'b1, 1'b1, 1'b0, 0));
      prog.push_back(mk(32'h44, 32'h0, 32'h1111_2222, 5'd1, 1'b1, 1'b0, 1'b1, 1'b1, 0));
      prog.push_back(mk(32'h48, 32'h0, 32'h3333_4444, 5'd2, 1'b1, 1'b0, 1'b1, 1'b1, 0));
      prog.push_back(mk(32'h50, 32'h0, 32'h5555_6666, 5'd4, 1'b1, 1'b0, 1'b1, 1'b1, NEVER));
      prog.push_back(mk(32'h42, 32'h0, 32'h7777_8888, 5'd6, 1'b1, 1'b0, 1'b1, 1'b1, 0));
      prog.push_back(mk(32'h60, 32'hCAFE_F00D, 32'h9999_AAAA, 5'd8, 1'b1, 1'b1, 1'b1, 1'b1, 1));
      for (int i = 0; i < 150; i++) prog.push_back(randInstr());
      prog.push_back(nop);

      rst = 1'b1;
      applyStimulus(nop);
      dmem.dmem_ack   = 1'b0;
      dmem.dmem_rdata = 32'h0;
      repeat (2) @(posedge clk);
      #2;
      checkAllClear("reset");
      rst = 1'b0;
      prev_reg  = 5'd0;
      prev_rw   = 1'b0;
      prev_data = 32'h0;
      applyStimulus(prog[0]);

      for (int i = 0; i < prog.size(); i++)
         runInstr(prog[i], (i + 1 < prog.size()) ? prog[i + 1] : lw_hang);

      @(posedge clk);
      #1;
      dmem.dmem_ack = 1'b0;
      applyStimulus(nop);
      #1;
      checkOutput("hang_req", 32'(dmem.dmem_req), 32'd1);
      checkOutput("hang_stall", 32'(mem_stall), 32'd1);
      rst = 1'b1;
      @(posedge clk);
      #2;
      checkAllClear("mid_access_reset");
      rst = 1'b0;

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
